// File: rtl/data_sram_axi_bridge.sv
// Bridges a single-outstanding core data request onto AXI read/write channels.
// Wait counter flags slow slaves; the transaction still completes normally.
//
// state   | meaning
// IDLE    | waiting for req_en, request latched on accept
// RD_ADDR | arvalid held until arready
// RD_DATA | rready held until rvalid, read data captured
// WR_REQ  | awvalid/wvalid each held until its own handshake
// WR_RESP | bready held until bvalid
// DONE    | one-cycle completion, req_rdata/req_err presented
module data_sram_axi_bridge #(
  parameter logic [15:0] MAX_WAIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  req_wen,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] req_rdata,
  output logic        req_stall,
  output logic        req_err,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wen_q;
  logic [1:0]  size_q;
  logic [15:0] wait_cnt;
  logic [15:0] wait_inc;
  logic        err_flag;
  logic        aw_pend;
  logic        w_pend;
  logic        timeout;
  logic        busy;
  logic        aw_done;
  logic        w_done;
  logic [1:0]  eff_size;

  assign busy     = (state != IDLE) && (state != DONE);
  assign wait_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
  assign timeout  = (MAX_WAIT != 16'd0) && (wait_inc == MAX_WAIT);
  assign aw_done  = !aw_pend || awready;
  assign w_done   = !w_pend || wready;
  assign eff_size = (req_size == 2'd3) ? 2'd2 : req_size;

  // Gated by rst so the stall drops immediately even while the core holds req_en.
  assign req_stall = rst && (((state == IDLE) && req_en) || busy);

  assign arvalid = (state == RD_ADDR);
  assign rready  = (state == RD_DATA);
  assign bready  = (state == WR_RESP);
  assign awvalid = aw_pend;
  assign wvalid  = w_pend;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign awsize  = {1'b0, size_q};
  assign wdata   = wdata_q;
  assign wstrb   = wen_q;
  assign wlast   = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= '0;
      size_q    <= '0;
      wait_cnt  <= '0;
      err_flag  <= 1'b0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      req_rdata <= '0;
      req_err   <= 1'b0;
    end else begin
      req_err <= 1'b0;
      if (busy) begin
        wait_cnt <= wait_inc;
        if (timeout) err_flag <= 1'b1;
      end
      case (state)
        IDLE: if (req_en) begin
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          wen_q    <= req_wen;
          size_q   <= eff_size;
          wait_cnt <= '0;
          err_flag <= 1'b0;
          if (req_wen == 4'd0) begin
            state <= RD_ADDR;
          end else begin
            state   <= WR_REQ;
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
          end
        end
        RD_ADDR: if (arready) state <= RD_DATA;
        RD_DATA: if (rvalid) begin
          req_rdata <= rdata;
          req_err   <= err_flag || timeout || (rresp != 2'd0);
          state     <= DONE;
        end
        WR_REQ: begin
          if (awready) aw_pend <= 1'b0;
          if (wready)  w_pend  <= 1'b0;
          if (aw_done && w_done) state <= WR_RESP;
        end
        WR_RESP: if (bvalid) begin
          req_err <= err_flag || timeout || (bresp != 2'd0);
          state   <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_sram_axi_bridge.md
DATA_SRAM_AXI_BRIDGE -- requirements
Module: data_sram_axi_bridge

Interface
REQ-001 The block SHALL have one parameter: MAX_WAIT, default 16'hFFFF, the AXI wait-cycle limit before req_err is flagged (0 disables the limit).
REQ-002 clk  input  1  the single clock; all sequential logic SHALL be on its rising edge.
REQ-003 rst  input  1  reset, SHALL be asynchronous and active-low.
REQ-004 req_en  input  1  core data request valid; held stable by the core while req_stall=1.
REQ-005 req_wen  input  4  byte write enables; 0 means read.
REQ-006 req_size  input  2  0 byte, 1 half, 2 word; 3 SHALL be treated as word.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_rdata  output  32  load data, valid in the DONE cycle.
REQ-010 req_stall  output  1  core stall request.
REQ-011 req_err  output  1  one-cycle pulse in DONE if the wait limit expired or resp!=0.
REQ-012 araddr/awaddr  output  32 each  latched req_addr.
REQ-013 arsize/awsize  output  3 each  {1'b0, effective size}.
REQ-014 arvalid, arready(in), rvalid(in), rready  1 each  AXI read address and data handshakes.
REQ-015 rdata  input  32;  rresp  input  2.
REQ-016 awvalid, awready(in), wvalid, wready(in), bvalid(in), bready  1 each  AXI write handshakes.
REQ-017 wdata  output  32;  wstrb  output  4 (latched req_wen);  wlast  output  1, constant 1;  bresp  input  2.

Function
REQ-018 States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE; one transaction outstanding at most.
REQ-019 IDLE and req_en=1: latch addr, size, wen, wdata; go to RD_ADDR if req_wen==0, else WR_REQ.
REQ-020 req_stall SHALL equal (IDLE & req_en) | (state not IDLE and not DONE), combinationally; req_stall SHALL be 0 in DONE.
REQ-021 RD_ADDR: arvalid=1; on arvalid&arready go to RD_DATA; arvalid SHALL NOT drop before the handshake.
REQ-022 RD_DATA: rready=1; on rvalid capture rdata into req_rdata and OR rresp!=0 into the error flag, then go to DONE.
REQ-023 WR_REQ: awvalid and wvalid asserted on entry, each deasserted independently after its own handshake; same-cycle completion of both SHALL be supported; when both are done go to WR_RESP.
REQ-024 WR_RESP: bready=1; on bvalid record bresp!=0 and go to DONE.
REQ-025 DONE: lasts exactly one cycle, then returns to IDLE; req_en in DONE SHALL be ignored, because it is the already-served request.
REQ-026 req_rdata SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-027 A 16-bit wait counter SHALL clear on leaving IDLE and increment each non-IDLE, non-DONE cycle; reaching MAX_WAIT (nonzero) sets the error flag, and the transaction SHALL still complete normally.
REQ-028 Minimum latency with zero-wait slave: read is IDLE->RD_ADDR->RD_DATA->DONE, so req_stall is high 3 cycles; write is IDLE->WR_REQ->WR_RESP->DONE, also 3 cycles.
REQ-029 rready is high only in RD_DATA and bready only in WR_RESP; any other AXI outputs outside their states SHALL be 0.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, all valid/ready outputs 0, req_rdata 0, req_err 0, counter 0, latched request 0; an in-flight transaction is abandoned and no DONE is produced.
REQ-031 After rst rises, the block SHALL accept a request in the first IDLE cycle.

Verification
REQ-032 Read of 0x1FC0_0010, size 2, arready=1, rvalid one cycle later with rdata=0xDEADBEEF -> req_stall high 3 cycles; DONE shows req_rdata=0xDEADBEEF, req_err=0.
REQ-033 Write with wen=4'b0011, addr 0x8000_0004, wdata 0x1234_5678; awready delayed 2 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid after 3; wstrb=0011; then bready, DONE.
REQ-034 Write with awready and wready in the same cycle, then bvalid with bresp=2'b10 -> WR_RESP is reached in one cycle, and req_err pulses in DONE.
REQ-035 MAX_WAIT=4 and a read where rvalid is withheld for 10 cycles -> req_err=1 in DONE, and req_rdata still captures the late rdata.
REQ-036 rst driven low during RD_DATA -> arvalid, rready and req_stall go to 0 asynchronously; after release, a new write completes normally.
